// File: rtl/hgcal_lnet_pkg.sv
// rtl/hgcal_lnet_pkg.sv - shared constants and types for the HGCAL autoencoder input path
// Contents:
//   INPUT_BITS, NUM_INPUTS, BEAT_W : base geometry of one frame of quantized cell codes
//   VEC_W, NUM_BEATS               : derived vector width and beats per frame
//   IDX_W                          : width of the beat index counter
//   beat_t, vec_t                  : one input beat, one assembled activation vector
package hgcal_lnet_pkg;

  localparam int INPUT_BITS = 2;
  localparam int NUM_INPUTS = 48;
  localparam int BEAT_W     = 32;

  localparam int VEC_W      = INPUT_BITS * NUM_INPUTS;
  localparam int NUM_BEATS  = VEC_W / BEAT_W;
  localparam int IDX_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  typedef logic [BEAT_W-1:0] beat_t;
  typedef logic [VEC_W-1:0]  vec_t;

endpackage

// File: rtl/lnet_out_reg.sv
// rtl/lnet_out_reg.sv - output register with valid/ready hold, shared by the layer feeders
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture d this edge (caller guarantees ~valid | ready)
//   d        : data to capture
//   ready    : downstream accepts when valid & ready
//   q        : registered data, stable while valid & ~ready
//   valid    : q holds an undelivered vector
module lnet_out_reg #(
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else begin
      if (load) begin
        q     <= d;
        valid <= 1'b1;
      end else if (ready) begin
        // consumed with nothing new behind it
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/layer0_input_deframer.sv
// rtl/layer0_input_deframer.sv - assembles NUM_BEATS input beats into one layer-0 activation vector
// Optional feature: FRAME_CNT_EN builds the delivered-frame counter; otherwise frame_cnt is tied to 0.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   s_data, s_valid, s_last, s_ready : beat input stream, s_last marks the final beat of a frame
//   m_data, m_valid, m_ready         : assembled vector to the layer-0 LUT bank
//   err_frame                        : one-cycle pulse after a beat that breaks framing
//   frame_cnt                        : count of delivered vectors, wraps at 16 bits
module layer0_input_deframer
  import hgcal_lnet_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [VEC_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              err_frame,
  output logic [15:0]       frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BEATS - 1);

  logic [IDX_W-1:0] beat_idx;
  vec_t             asm_q;
  vec_t             asm_next;
  logic             at_last;
  logic             accept;
  logic             bad_frame;
  logic             load_out;

  assign at_last = (beat_idx == LAST_IDX);

  // Only the final beat needs room in the output register; earlier beats
  // land in the assembly register, so they are never back-pressured.
  assign s_ready   = ~at_last | ~m_valid | m_ready;
  assign accept    = s_valid & s_ready;
  assign bad_frame = accept & (s_last ^ at_last);
  assign load_out  = accept & s_last & at_last;

  // Slot the incoming beat into its position. On the final beat this is the
  // complete vector, which is what the output register captures.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (beat_idx == IDX_W'(k)) begin
        asm_next[k*BEAT_W +: BEAT_W] = s_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_idx  <= '0;
      asm_q     <= '0;
      err_frame <= 1'b0;
    end else begin
      err_frame <= bad_frame;
      if (accept) begin
        asm_q <= asm_next;
        // End of frame, good or bad, restarts assembly; the offending beat is dropped.
        if (s_last || at_last) begin
          beat_idx <= '0;
        end else begin
          beat_idx <= beat_idx + IDX_W'(1);
        end
      end
    end
  end

  lnet_out_reg #(
    .WIDTH (VEC_W)
  ) u_out_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (load_out),
    .d     (asm_next),
    .ready (m_ready),
    .q     (m_data),
    .valid (m_valid)
  );

`ifdef FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (m_valid && m_ready) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_layer0_input_deframer.sv
// tb/tb_layer0_input_deframer.sv - self-checking bench for layer0_input_deframer
module tb_layer0_input_deframer;
  import hgcal_lnet_pkg::*;

  logic              clk;
  logic              rst;
  logic [BEAT_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [VEC_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready;
  logic              err_frame;
  logic [15:0]       frame_cnt;

  layer0_input_deframer dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_frame (err_frame),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [VEC_W-1:0] got, input logic [VEC_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a frame is the list of beats seen since the last frame end.
  beat_t       beats[$];
  logic        mod_valid;
  vec_t        mod_data;
  logic        exp_err;
  int          delivered;
  int          dut_hs;

  task automatic model_reset();
    beats.delete();
    mod_valid = 1'b0;
    mod_data  = '0;
    exp_err   = 1'b0;
    delivered = 0;
  endtask

  // One clock: drive inputs, compare at the falling edge, advance the model.
  task automatic cycle(input logic sv, input beat_t d, input logic sl, input logic mr);
    logic exp_ready;
    logic acc;
    vec_t v;
    s_valid = sv;
    s_data  = d;
    s_last  = sl;
    m_ready = mr;
    @(negedge clk);
    exp_ready = (beats.size() != NUM_BEATS - 1) || !mod_valid || mr;
    check("s_ready", VEC_W'(s_ready), VEC_W'(exp_ready));
    check("m_valid", VEC_W'(m_valid), VEC_W'(mod_valid));
    if (mod_valid) check("m_data", m_data, mod_data);
    check("err_frame", VEC_W'(err_frame), VEC_W'(exp_err));
`ifdef FRAME_CNT_EN
    check("frame_cnt", VEC_W'(frame_cnt), VEC_W'(delivered[15:0]));
`else
    check("frame_cnt", VEC_W'(frame_cnt), '0);
`endif
    if (m_valid && m_ready) dut_hs++;
    exp_err = 1'b0;
    if (mod_valid && mr) begin
      mod_valid = 1'b0;
      delivered++;
    end
    acc = sv && exp_ready;
    if (acc) begin
      beats.push_back(d);
      if (sl || beats.size() == NUM_BEATS) begin
        if (sl && beats.size() == NUM_BEATS) begin
          v = '0;
          for (int k = 0; k < NUM_BEATS; k++) v[k*BEAT_W +: BEAT_W] = beats[k];
          mod_data  = v;
          mod_valid = 1'b1;
        end else begin
          exp_err = 1'b1;
        end
        beats.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic mr);
    for (int k = 0; k < NUM_BEATS; k++) cycle(1'b1, $urandom, (k == NUM_BEATS - 1), mr);
  endtask

  int   err_pulses;
  int   hs_before;
  beat_t bb;
  logic sl_r;

  initial begin
    n_checks = 0;
    n_errors = 0;
    dut_hs   = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    m_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", VEC_W'(m_valid), '0);
    check("rst_m_data", m_data, '0);
    check("rst_err", VEC_W'(err_frame), '0);
    check("rst_frame_cnt", VEC_W'(frame_cnt), '0);
    rst = 1'b0;

    // Directed first frame
    cycle(1'b1, 32'h0000_0001, 1'b0, 1'b1);
    cycle(1'b1, 32'h0000_0002, 1'b0, 1'b1);
    cycle(1'b1, 32'h8000_0003, 1'b1, 1'b1);
    check("t1_valid", VEC_W'(m_valid), VEC_W'(1));
    check("t1_data", m_data, 96'h8000_0003_0000_0002_0000_0001);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Ten back-to-back frames, consumer always ready
    hs_before = dut_hs;
    for (int f = 0; f < 10; f++) send_frame(1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("t2_handshakes", VEC_W'(dut_hs - hs_before), VEC_W'(10));

    // Back-pressure: A held, B's last beat stalls, then both move on one edge
    send_frame(1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    bb = $urandom;
    cycle(1'b1, bb, 1'b1, 1'b0);
    check("t3_stalled", VEC_W'(s_ready), '0);
    cycle(1'b1, bb, 1'b1, 1'b1);
    check("t3_valid_kept", VEC_W'(m_valid), VEC_W'(1));
    check("t3_b_top", VEC_W'(m_data[VEC_W-1 -: BEAT_W]), VEC_W'(bb));
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Early s_last on beat 2, then a good frame
    err_pulses = 0;
    cycle(1'b1, $urandom, 1'b0, 1'b1);
    cycle(1'b1, $urandom, 1'b1, 1'b1);
    if (err_frame) err_pulses++;
    cycle(1'b0, '0, 1'b0, 1'b1);
    if (err_frame) err_pulses++;
    check("t4_err_once", VEC_W'(err_pulses), VEC_W'(1));
    check("t4_no_valid", VEC_W'(m_valid), '0);
    send_frame(1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Missing s_last on the final beat
    cycle(1'b1, $urandom, 1'b0, 1'b1);
    cycle(1'b1, $urandom, 1'b0, 1'b1);
    cycle(1'b1, $urandom, 1'b0, 1'b1);
    check("t4b_err", VEC_W'(err_frame), VEC_W'(1));
    check("t4b_no_valid", VEC_W'(m_valid), '0);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Reset mid-frame
    send_frame(1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("t5_rst_valid", VEC_W'(m_valid), '0);
    check("t5_rst_data", m_data, '0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_frame(1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with occasional framing errors
    for (int i = 0; i < 3000; i++) begin
      if (beats.size() == NUM_BEATS - 1) sl_r = ($urandom_range(15) != 0);
      else                               sl_r = ($urandom_range(15) == 0);
      cycle(($urandom_range(3) != 0), $urandom, sl_r, ($urandom_range(2) != 0));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
